// File: rtl/pipe_hazard_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_pkg : shared types and helpers for the pipeline hazard unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package pipe_hazard_pkg;

  // Widest register select an entry can hold; narrower selects are zero-extended.
  localparam int HZ_WS_W = 8;

  typedef struct packed {
    logic               valid;
    logic               wr;
    logic [HZ_WS_W-1:0] ws;
    logic               is_load;
  } hz_entry_t;

  localparam hz_entry_t HZ_BUBBLE = '0;

  function automatic int hz_fsw(input int nstages);
    return (nstages < 1) ? 1 : $clog2(nstages + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_match.sv
// ---------------------------------------------------------------------------
// hazard_match : compares one source operand against every tracked stage,
// reporting the youngest matching stage and whether it holds a load. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module hazard_match
  import pipe_hazard_pkg::*;
#(
  parameter int REG_AW  = 3,
  parameter int NSTAGES = 3,
  parameter int FSW     = 2
) (
  input  logic [REG_AW-1:0]        i_src_sel,
  input  logic                     i_src_used,
  input  hz_entry_t [NSTAGES:1]    i_entries,
  output logic                     o_hit,
  output logic [FSW-1:0]           o_stage_idx,
  output logic                     o_is_load
);

  logic [HZ_WS_W-1:0] w_src_ext;

  assign w_src_ext = HZ_WS_W'(i_src_sel);

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    o_hit       = 1'b0;
    o_stage_idx = '0;
    o_is_load   = 1'b0;
    for (int k = NSTAGES; k >= 1; k--) begin
      if (i_src_used && i_entries[k].valid && i_entries[k].wr &&
          (i_entries[k].ws == w_src_ext)) begin
        o_hit       = 1'b1;
        o_stage_idx = FSW'(k);
        o_is_load   = i_entries[k].is_load;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_unit.sv
// ---------------------------------------------------------------------------
// pipe_hazard_unit : load-use stall and operand forwarding control.
// Forwarding is enabled by defining PIPE_HAZARD_FWD_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module pipe_hazard_unit
  import pipe_hazard_pkg::*;
#(
  parameter  int REG_AW     = 3,
  parameter  int NSRC       = 2,
  parameter  int NSTAGES    = 3,
  parameter  int LOAD_READY = 2,
  parameter  int CNT_W      = 16,
  localparam int FSW        = hz_fsw(NSTAGES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     id_valid,
  input  logic [NSRC*REG_AW-1:0]   id_src_sel,
  input  logic [NSRC-1:0]          id_src_used,
  input  logic                     id_wr,
  input  logic [REG_AW-1:0]        id_ws,
  input  logic                     id_is_load,
  input  logic                     flush,
  input  logic                     freeze,
  output logic                     stall,
  output logic [NSRC*FSW-1:0]      fwd_sel,
  output logic [CNT_W-1:0]         stall_cnt
);

  hz_entry_t [NSTAGES:1] r_entry;
  logic [CNT_W-1:0]      r_stall_cnt;

  hz_entry_t             w_id_entry;
  logic [NSRC-1:0]       w_hit;
  logic [NSRC-1:0]       w_ld;
  logic [NSRC-1:0]       w_load_block;
  logic [NSRC-1:0]       w_block;
  logic [FSW-1:0]        w_idx [NSRC];
  logic                  w_stall;
  logic                  w_record;

  assign w_id_entry.valid   = 1'b1;
  assign w_id_entry.wr      = id_wr;
  assign w_id_entry.ws      = HZ_WS_W'(id_ws);
  assign w_id_entry.is_load = id_is_load;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    hazard_match #(
      .REG_AW  (REG_AW),
      .NSTAGES (NSTAGES),
      .FSW     (FSW)
    ) u_match (
      .i_src_sel   (id_src_sel[i*REG_AW +: REG_AW]),
      .i_src_used  (id_src_used[i]),
      .i_entries   (r_entry),
      .o_hit       (w_hit[i]),
      .o_stage_idx (w_idx[i]),
      .o_is_load   (w_ld[i])
    );

    // Youngest producer is a load whose data is not yet available.
    assign w_load_block[i] = w_hit[i] & w_ld[i] & (int'(w_idx[i]) < LOAD_READY);

`ifdef PIPE_HAZARD_FWD_EN
    assign w_block[i]              = w_load_block[i];
    assign fwd_sel[i*FSW +: FSW]   = w_load_block[i] ? '0 : w_idx[i];
`else
    // No bypass paths: any in-flight producer blocks. The load term is a
    // subset of w_hit and leaves the result unchanged.
    assign w_block[i]              = w_hit[i] | w_load_block[i];
    assign fwd_sel[i*FSW +: FSW]   = '0;
`endif
  end

  assign w_stall   = (|w_block) & id_valid & ~flush;
  assign w_record  = id_valid & ~w_stall & ~flush;
  assign stall     = w_stall;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_entry     <= {NSTAGES{HZ_BUBBLE}};
      r_stall_cnt <= '0;
    end else if (!freeze) begin
      for (int k = NSTAGES; k >= 2; k--) begin
        r_entry[k] <= r_entry[k-1];
      end
      r_entry[1] <= w_record ? w_id_entry : HZ_BUBBLE;
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire
